// File: rtl/iterative_alu_if.sv
// Request/response bundle between the ID/EX stage, the iterative ALU and the hazard unit.
// The slave modport is the ALU side. The master modport is the pipeline/bench side.
interface iterative_alu_if #(
  parameter int XLEN = 32
);
  // Handshake: a request is taken on a rising edge where valid_i & ready_o & ~flush_i.
  // valid_o is a one-cycle pulse marking a new Result_o/Zero_o. There is no back-pressure
  // on the response side.
  logic            valid_i;
  logic [3:0]      ALUCtrl_i;
  logic [XLEN-1:0] OperandA_i;
  logic [XLEN-1:0] OperandB_i;
  logic            flush_i;
  logic            ready_o;
  logic            valid_o;
  logic [XLEN-1:0] Result_o;
  logic            Zero_o;
  logic            dbg_state_o;

  modport slave (
    input  valid_i, ALUCtrl_i, OperandA_i, OperandB_i, flush_i,
    output ready_o, valid_o, Result_o, Zero_o, dbg_state_o
  );

  modport master (
    output valid_i, ALUCtrl_i, OperandA_i, OperandB_i, flush_i,
    input  ready_o, valid_o, Result_o, Zero_o, dbg_state_o
  );
endinterface

// File: rtl/iterative_alu.sv
// Execute-stage ALU. Logic and add/sub ops finish in one cycle. Shifts run one bit per cycle
// through a work register, and the unit is not ready while a shift is running.
module iterative_alu #(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = 5
) (
  input  logic            clk_i,
  input  logic            rst_i,
  iterative_alu_if.slave  bus
);

  typedef enum logic {S_IDLE = 1'b0, S_SHIFT = 1'b1} state_t;
  typedef enum logic [1:0] {OP_SLL = 2'd0, OP_SRL = 2'd1, OP_SRA = 2'd2} shop_t;

  state_t             r_state, w_state_nxt;
  shop_t              r_op, w_op_nxt, w_op_sel;
  logic [XLEN-1:0]    r_work, w_work_nxt;
  logic [SHAMT_W-1:0] r_cnt, w_cnt_nxt;
  logic [XLEN-1:0]    r_result, w_result_nxt;
  logic               r_zero, w_zero_nxt;
  logic               r_valid, w_valid_nxt;

  logic               w_accept;
  logic               w_is_shift;
  logic [SHAMT_W-1:0] w_shamt;
  logic [XLEN-1:0]    w_single;
  logic [XLEN-1:0]    w_shifted;

  assign w_shamt  = bus.OperandB_i[SHAMT_W-1:0];
  assign w_accept = bus.valid_i & (r_state == S_IDLE) & ~bus.flush_i;

  // Single-cycle result. A shift by zero is just OperandA. Unused codes produce zero.
  always_comb begin
    w_single   = '0;
    w_is_shift = 1'b0;
    w_op_sel   = OP_SLL;
    case (bus.ALUCtrl_i)
      4'b0000: w_single = bus.OperandA_i + bus.OperandB_i;
      4'b0001: w_single = bus.OperandA_i - bus.OperandB_i;
      4'b0010: begin w_single = bus.OperandA_i; w_is_shift = 1'b1; w_op_sel = OP_SLL; end
      4'b0011: w_single = bus.OperandA_i ^ bus.OperandB_i;
      4'b0100: begin w_single = bus.OperandA_i; w_is_shift = 1'b1; w_op_sel = OP_SRL; end
      4'b0101: begin w_single = bus.OperandA_i; w_is_shift = 1'b1; w_op_sel = OP_SRA; end
      4'b0110: w_single = bus.OperandA_i | bus.OperandB_i;
      4'b0111: w_single = bus.OperandA_i & bus.OperandB_i;
      4'b1000: w_single = bus.OperandB_i;
      default: w_single = '0;
    endcase
  end

  always_comb begin
    w_shifted = r_work;
    case (r_op)
      OP_SLL:  w_shifted = {r_work[XLEN-2:0], 1'b0};
      OP_SRL:  w_shifted = {1'b0, r_work[XLEN-1:1]};
      OP_SRA:  w_shifted = {r_work[XLEN-1], r_work[XLEN-1:1]};
      default: w_shifted = r_work;
    endcase
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_op_nxt     = r_op;
    w_work_nxt   = r_work;
    w_cnt_nxt    = r_cnt;
    w_result_nxt = r_result;
    w_zero_nxt   = r_zero;
    w_valid_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_is_shift && (w_shamt != '0)) begin
            w_work_nxt  = bus.OperandA_i;
            w_cnt_nxt   = w_shamt;
            w_op_nxt    = w_op_sel;
            w_state_nxt = S_SHIFT;
          end else begin
            w_result_nxt = w_single;
            w_zero_nxt   = (w_single == '0);
            w_valid_nxt  = 1'b1;
          end
        end
      end
      S_SHIFT: begin
        if (bus.flush_i) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_work_nxt = w_shifted;
          w_cnt_nxt  = r_cnt - SHAMT_W'(1);
          // Last step: publish the shifted value straight from the shifter output.
          if (r_cnt == SHAMT_W'(1)) begin
            w_result_nxt = w_shifted;
            w_zero_nxt   = (w_shifted == '0);
            w_valid_nxt  = 1'b1;
            w_state_nxt  = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state  <= S_IDLE;
      r_op     <= OP_SLL;
      r_work   <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_zero   <= 1'b0;
      r_valid  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_op     <= w_op_nxt;
      r_work   <= w_work_nxt;
      r_cnt    <= w_cnt_nxt;
      r_result <= w_result_nxt;
      r_zero   <= w_zero_nxt;
      r_valid  <= w_valid_nxt;
    end
  end

  assign bus.ready_o     = (r_state == S_IDLE);
  assign bus.valid_o     = r_valid;
  assign bus.Result_o    = r_result;
  assign bus.Zero_o      = r_zero;
  assign bus.dbg_state_o = r_state;

endmodule

// File: tb/tb_iterative_alu.sv
// Directed bench for iterative_alu. Expected results are queued when an op is issued.
// A negedge monitor pops and compares them on every valid_o pulse.
module tb_iterative_alu;
  localparam int XLEN = 32;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;

  iterative_alu_if #(.XLEN(XLEN)) bus ();

  iterative_alu #(.XLEN(XLEN), .SHAMT_W(5)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus.slave)
  );

  // clock / reset
  always #5 clk_i = ~clk_i;

  int n_vec = 0;
  int n_err = 0;
  logic [XLEN:0] exp_q[$];

  task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk_i) begin
    if (!rst_i && bus.valid_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_valid: got result 0x%08h, expected no valid_o at %0t", bus.Result_o, $time);
      end else begin
        logic [XLEN:0] e;
        e = exp_q.pop_front();
        check("result", bus.Result_o, e[XLEN-1:0]);
        check("zero", {31'd0, bus.Zero_o}, {31'd0, e[XLEN]});
      end
    end
  end

  // driver tasks
  task automatic drive(input logic [3:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    bus.valid_i    = 1'b1;
    bus.ALUCtrl_i  = op;
    bus.OperandA_i = a;
    bus.OperandB_i = b;
  endtask

  task automatic expect_res(input logic [XLEN-1:0] res);
    exp_q.push_back({(res == '0), res});
  endtask

  task automatic step_accept();
    @(posedge clk_i);
    #1;
    bus.valid_i = 1'b0;
  endtask

  task automatic wait_done(input int lat);
    for (int i = 0; i < lat; i++) begin
      @(negedge clk_i);
      check("busy_ready", {31'd0, bus.ready_o}, 32'd0);
      check("busy_valid", {31'd0, bus.valid_o}, 32'd0);
    end
    @(negedge clk_i);
    check("done_valid", {31'd0, bus.valid_o}, 32'd1);
    check("done_ready", {31'd0, bus.ready_o}, 32'd1);
  endtask

  task automatic run_op(input logic [3:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                        input logic [XLEN-1:0] res, input int lat);
    drive(op, a, b);
    expect_res(res);
    step_accept();
    wait_done(lat);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.valid_i    = 1'b0;
    bus.ALUCtrl_i  = 4'd0;
    bus.OperandA_i = '0;
    bus.OperandB_i = '0;
    bus.flush_i    = 1'b0;

    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;
    @(negedge clk_i);
    check("rst_ready", {31'd0, bus.ready_o}, 32'd1);
    check("rst_valid", {31'd0, bus.valid_o}, 32'd0);
    check("rst_result", bus.Result_o, 32'd0);
    check("rst_zero", {31'd0, bus.Zero_o}, 32'd0);

    // add, then idle cycle must not pulse valid_o
    run_op(4'b0000, 32'd5, 32'd7, 32'd12, 0);
    @(negedge clk_i);
    check("idle_valid", {31'd0, bus.valid_o}, 32'd0);
    check("idle_hold", bus.Result_o, 32'd12);

    // sub then pass-B back to back
    drive(4'b0001, 32'd3, 32'd3);
    expect_res(32'd0);
    @(posedge clk_i);
    #1;
    drive(4'b1000, 32'hDEADBEEF, 32'h12345000);
    expect_res(32'h12345000);
    @(negedge clk_i);
    check("b2b_valid1", {31'd0, bus.valid_o}, 32'd1);
    check("b2b_ready1", {31'd0, bus.ready_o}, 32'd1);
    @(posedge clk_i);
    #1 bus.valid_i = 1'b0;
    @(negedge clk_i);
    check("b2b_valid2", {31'd0, bus.valid_o}, 32'd1);
    @(negedge clk_i);
    check("b2b_valid3", {31'd0, bus.valid_o}, 32'd0);

    // single-cycle ops and edge values
    run_op(4'b0011, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 0);
    run_op(4'b0110, 32'h12340000, 32'h00005678, 32'h12345678, 0);
    run_op(4'b0111, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 0);
    run_op(4'b1011, 32'h11111111, 32'h22222222, 32'h00000000, 0);
    run_op(4'b0000, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 0);
    run_op(4'b0001, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 0);

    // shifts
    run_op(4'b0101, 32'h80000000, 32'd4, 32'hF8000000, 4);
    run_op(4'b0100, 32'h80000000, 32'd4, 32'h08000000, 4);
    run_op(4'b0101, 32'h7FFFFFF0, 32'd4, 32'h07FFFFFF, 4);
    run_op(4'b0010, 32'h000000A5, 32'h00000020, 32'h000000A5, 0);
    run_op(4'b0010, 32'h00000003, 32'hFFFFFFE1, 32'h00000006, 1);

    // operand changes during a shift are ignored
    drive(4'b0101, 32'hFFFF0000, 32'd16);
    expect_res(32'hFFFFFFFF);
    step_accept();
    bus.ALUCtrl_i  = 4'b0000;
    bus.OperandA_i = 32'd0;
    bus.OperandB_i = 32'd3;
    wait_done(16);

    run_op(4'b0010, 32'h00000001, 32'd31, 32'h80000000, 31);

    // flush mid-shift
    drive(4'b0100, 32'h000000FF, 32'd8);
    step_accept();
    @(negedge clk_i);
    check("fl_ready1", {31'd0, bus.ready_o}, 32'd0);
    @(posedge clk_i);
    #1 bus.flush_i = 1'b1;
    @(posedge clk_i);
    #1 bus.flush_i = 1'b0;
    @(negedge clk_i);
    check("fl_ready4", {31'd0, bus.ready_o}, 32'd1);
    check("fl_valid", {31'd0, bus.valid_o}, 32'd0);
    check("fl_result", bus.Result_o, 32'h80000000);
    repeat (8) @(negedge clk_i);
    check("fl_hold", bus.Result_o, 32'h80000000);

    // flush beats a request in IDLE
    drive(4'b0000, 32'd1, 32'd1);
    bus.flush_i = 1'b1;
    step_accept();
    bus.flush_i = 1'b0;
    @(negedge clk_i);
    check("fli_valid", {31'd0, bus.valid_o}, 32'd0);
    check("fli_ready", {31'd0, bus.ready_o}, 32'd1);
    check("fli_result", bus.Result_o, 32'h80000000);

    // async reset mid-shift
    drive(4'b0010, 32'h00000001, 32'd10);
    step_accept();
    repeat (3) @(negedge clk_i);
    #2 rst_i = 1'b1;
    #1;
    check("ar_result", bus.Result_o, 32'd0);
    check("ar_valid", {31'd0, bus.valid_o}, 32'd0);
    check("ar_zero", {31'd0, bus.Zero_o}, 32'd0);
    check("ar_ready", {31'd0, bus.ready_o}, 32'd1);
    @(posedge clk_i);
    #1 rst_i = 1'b0;
    repeat (12) @(negedge clk_i);
    check("ar_quiet", bus.Result_o, 32'd0);
    run_op(4'b0000, 32'h7FFFFFFF, 32'd1, 32'h80000000, 0);

    repeat (3) @(negedge clk_i);
    check("queue_empty", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/iterative_alu.md
Name: iterative_alu

Overview:
- Execute-stage ALU that consumes the 4-bit ALU control code produced by the ALU decode logic.
- Logic and add/sub ops complete in one cycle.
- Shifts (SLL/SRL/SRA) use a one-bit-per-cycle iterative shifter, which trades latency for area.
- Sits between the ID/EX register and EX/MEM. The hazard unit stalls upstream on ready_o and consumes the valid_o pulse.

Parameters:
- XLEN, 32, operand/result width.
- SHAMT_W, 5, shift-amount width; equals log2(XLEN).

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- valid_i  input  1  operation request.
- ALUCtrl_i  input  4  op code: 0000 add, 0001 sub, 0010 sll, 0011 xor, 0100 srl, 0101 sra, 0110 or, 0111 and, 1000 pass OperandB (LUI).
- OperandA_i  input  XLEN  source A.
- OperandB_i  input  XLEN  source B; bits [SHAMT_W-1:0] are the shift amount.
- flush_i  input  1  abort in-flight op, drop request.
- ready_o  output  1  can accept a request this cycle.
- valid_o  output  1  one-cycle pulse: Result_o/Zero_o hold a new result.
- Result_o  output  XLEN  registered result.
- Zero_o  output  1  registered (Result_o == 0).

Behaviour:
- Reset (async, any state incl. mid-shift): state=IDLE, Result_o=0, Zero_o=0, valid_o=0, shift counter=0, work reg=0. ready_o=1 once state is IDLE.
- States:
  - IDLE: ready_o=1.
  - SHIFT: ready_o=0.
  - ready_o is decoded from state only, with no combinational path from valid_i.
- Accept: valid_i & ready_o & ~flush_i at rising edge t.
- Single-cycle ops: add, sub, xor, or, and, 1000, codes 1001-1111, and any shift with shamt==0.
  - At edge t: Result_o and Zero_o are loaded and valid_o=1 during cycle t+1.
  - State stays IDLE.
  - Codes 1001-1111 produce Result_o=0, Zero_o=1.
- Arithmetic: add/sub are modulo 2^XLEN with no flags. 1000 passes OperandB_i unchanged.
- Shifts with shamt N>0:
  - At edge t: work reg=OperandA_i, counter=N, op latched, state goes IDLE->SHIFT, valid_o stays 0.
  - Each following edge: work reg shifts one bit and the counter decrements.
    - sll: fill 0.
    - srl: fill 0.
    - sra: replicate bit XLEN-1.
  - On the edge where the counter goes 1->0: Result_o=final shifted value, Zero_o updated, valid_o=1, state goes SHIFT->IDLE.
  - The result is visible in cycle t+1+N, and ready_o is 0 for cycles t+1..t+N.
- valid_o is high for exactly one cycle per completed op and clears on the next edge unless another completion occurs.
- Back-to-back ops: ready_o=1 in the cycle valid_o is high, so a new accept there gives consecutive valid_o pulses.
- Result_o and Zero_o hold their last value between completions.
- Operands are sampled only at accept; input changes during SHIFT are ignored.
- flush_i:
  - In SHIFT: next edge returns to IDLE, no valid_o, Result_o/Zero_o unchanged.
  - In IDLE with valid_i: the request is dropped. Flush has priority over accept.
  - A valid_o already scheduled in the current cycle is not retracted.
- valid_i=0 in IDLE: no state change, valid_o=0 next cycle.

Test Plan:
- Reset then add:
  - Stimulus: reset held 3 cycles, then valid_i=1, ALUCtrl=0000, A=5, B=7 at edge t.
  - Required: ready_o=1 throughout, valid_o=1 at t+1 only, Result_o=12, Zero_o=0.
- Sub then pass-B back-to-back:
  - Stimulus: sub A=3, B=3, then 1000 with B=0x12345000 accepted at t+1.
  - Required: Result_o=0/Zero_o=1 at t+1, then 0x12345000/Zero_o=0 at t+2, valid_o high at both t+1 and t+2.
- Arithmetic shift:
  - Stimulus: ALUCtrl=0101, A=0x80000000, B=4 at t.
  - Required: ready_o=0 at t+1..t+4, valid_o=1 only at t+5, Result_o=0xF8000000.
  - Repeat with 0100 (srl): Result_o=0x08000000.
- Zero-shift and max shift:
  - sll with B=0x20 (shamt 0), A=0xA5: single-cycle, Result_o=0xA5.
  - sll with A=1, B=31: valid_o at t+32, Result_o=0x80000000.
- Flush mid-shift:
  - Stimulus: srl A=0xFF, B=8 accepted at t, flush_i=1 at t+3.
  - Required: ready_o=1 at t+4, no valid_o, Result_o keeps its previous value.
  - Also: flush_i with valid_i in IDLE produces no accept.
- Reset mid-shift:
  - Stimulus: assert rst_i asynchronously between edges during SHIFT.
  - Required: immediately Result_o=0, valid_o=0, Zero_o=0; after release, ready_o=1 and a new add completes normally.
